// File: rtl/jk_bank_driver.sv
// jk_bank_driver
// Drives a parallel bank of external JK flip-flops to a requested value.
// A request (LOAD/SET/CLEAR/TOGGLE) is accepted on a valid/ready handshake,
// turned into a target relative to the bank's current Q, and applied as one
// registered J/K strobe per bit. The bank's Q is then checked against the
// target; a mismatch is re-driven up to MAX_RETRY extra times before err.

module jk_bank_driver #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          USE_TOGGLE = 1'b0,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [1:0]       tgt_op,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] tgt_val,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       retry_cnt;
  logic [3:0]       retry_nx;
  logic [WIDTH-1:0] j_nx;
  logic [WIDTH-1:0] k_nx;
  logic [WIDTH-1:0] tgt_nx;
  logic             done_nx;
  logic             err_nx;

  logic [WIDTH-1:0] req_tgt;
  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] exc_diff;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  assign tgt_ready = (state == IDLE);

  // Target implied by the incoming request relative to the bank's current Q.
  always_comb begin
    req_tgt = tgt_data;
    unique case (op_t'(tgt_op))
      OP_LOAD:   req_tgt = tgt_data;
      OP_SET:    req_tgt = q_fb | tgt_data;
      OP_CLEAR:  req_tgt = q_fb & ~tgt_data;
      OP_TOGGLE: req_tgt = q_fb ^ tgt_data;
      default:   req_tgt = tgt_data;
    endcase
  end

  // JK excitation of q_fb toward the active target (new request in IDLE,
  // latched target on a retry); unchanged bits always get J=K=0.
  always_comb begin
    exc_tgt  = (state == IDLE) ? req_tgt : tgt_val;
    exc_diff = q_fb ^ exc_tgt;
    if (USE_TOGGLE) begin
      exc_j = exc_diff;
      exc_k = exc_diff;
    end else begin
      exc_j = exc_diff & exc_tgt;
      exc_k = exc_diff & ~exc_tgt;
    end
  end

  // Next-state and registered-output logic for the IDLE/DRIVE/CHECK sequence.
  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    j_nx     = j;
    k_nx     = k;
    tgt_nx   = tgt_val;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tgt_valid) begin
          tgt_nx   = req_tgt;
          retry_nx = '0;
          j_nx     = exc_j;
          k_nx     = exc_k;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        // The bank samples j/k on this edge; release the strobes right after.
        j_nx     = '0;
        k_nx     = '0;
        state_nx = CHECK;
      end
      CHECK: begin
        if (q_fb == tgt_val) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (retry_cnt < RETRY_LIMIT) begin
          retry_nx = retry_cnt + 4'd1;
          j_nx     = exc_j;
          k_nx     = exc_k;
          state_nx = DRIVE;
        end else begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        j_nx     = '0;
        k_nx     = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      retry_cnt <= '0;
      j         <= '0;
      k         <= '0;
      tgt_val   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      retry_cnt <= retry_nx;
      j         <= j_nx;
      k         <= k_nx;
      tgt_val   <= tgt_nx;
      done      <= done_nx;
      err       <= err_nx;
    end
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Drives a parallel bank of WIDTH external JK flip-flops to a requested value using the JK excitation table. A request arrives on a valid/ready handshake and is checked against the bank's Q feedback. The block sits upstream of the JK register bank and generates one J/K strobe per bit. It verifies the result and retries up to MAX_RETRY times before flagging an error.

## Interface
- WIDTH, 8: number of JK flops in the driven bank.
- USE_TOGGLE, 0: if 1, every changing bit is driven with J=K=1; if 0, it is driven with J=1/K=0 (0→1) or J=0/K=1 (1→0).
- MAX_RETRY, 2: extra DRIVE attempts after the first failed check (0–15).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tgt_valid  in  1  request valid.
- tgt_ready  out  1  high exactly when the FSM is in IDLE.
- tgt_op  in  2  operation code: 00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE.
- tgt_data  in  WIDTH  operand.
- q_fb  in  WIDTH  Q outputs of the driven bank.
- j  out  WIDTH  J inputs to the bank (registered).
- k  out  WIDTH  K inputs to the bank (registered).
- tgt_val  out  WIDTH  currently latched target.
- done  out  1  one-cycle pulse: target reached.
- err  out  1  one-cycle pulse: retries exhausted.

## Operation
- FSM states: IDLE, DRIVE, CHECK. Reset state is IDLE.
- IDLE:
  - An accept occurs when tgt_valid and tgt_ready are both high at an edge.
  - On accept, the target is computed from the operation:
    - LOAD: target = tgt_data.
    - SET: target = q_fb | tgt_data.
    - CLEAR: target = q_fb & ~tgt_data.
    - TOGGLE: target = q_fb ^ tgt_data.
  - The target is latched into tgt_val and retry_cnt is cleared.
  - j/k are loaded from the excitation of q_fb versus the target.
  - Next state is DRIVE.
- Excitation per bit:
  - Unchanged bit: J=0, K=0.
  - Changing bit: driven per USE_TOGGLE as defined in the parameter list.
  - J=K=1 never appears when USE_TOGGLE=0.
- DRIVE (one cycle):
  - j/k hold their computed values; the bank samples them on the edge that leaves DRIVE.
  - On that edge, j and k are cleared to 0 and the next state is CHECK.
- CHECK (one cycle): q_fb is compared with tgt_val at the edge.
  - Equal: done is pulsed and the next state is IDLE.
  - Unequal with retry_cnt < MAX_RETRY: retry_cnt increments, j/k are recomputed from the current q_fb, and the next state is DRIVE.
  - Unequal with retry_cnt == MAX_RETRY: err is pulsed, done stays 0, and the next state is IDLE.
- A request whose target already equals q_fb still runs DRIVE (j=k=0) and CHECK, then pulses done.
- tgt_valid while busy: ignored (tgt_ready=0). The request is accepted on the first IDLE edge at which tgt_valid is still high.
- tgt_op and tgt_data are sampled only at accept; later changes have no effect.
- done and err are never high in the same cycle.

## Timing
- Reset values: state IDLE, j=0, k=0, tgt_val=0, done=0, err=0, retry_cnt=0. tgt_ready=1.
- Reset asserted mid-operation: all outputs go to their reset values asynchronously; j/k drop to 0 immediately.
- Nominal latency:
  - Accept at edge E0.
  - j/k valid in cycle E0→E1.
  - Bank updates at E1.
  - Compare at E2.
  - done is high in cycle E2→E3.
- Each retry adds 2 cycles. Worst case: err is high 2·(MAX_RETRY+1) cycles after accept.
- Throughput: done and tgt_ready are high in the same cycle, so a new request can be accepted at E3. The minimum request period is 3 cycles.
- q_fb is assumed to reflect the bank's registered Q with zero extra latency.

## Test plan
- **Reset:** assert reset_n=0 with random inputs.
  - Required: j=k=0, tgt_val=0, done=err=0, tgt_ready=1 throughout.
- **LOAD:** bench JK bank model starts at q=0x00; accept LOAD 0xA5 with USE_TOGGLE=0.
  - Required: j=0xA5, k=0x00 for one cycle; done pulse at E2→E3; q=0xA5.
- **TOGGLE:** q=0xA5; accept TOGGLE 0x0F with USE_TOGGLE=1.
  - Required: j=k=0x0F; tgt_val=0xAA; done pulse; q=0xAA.
- **SET then CLEAR:** q=0xAA.
  - SET 0x05 gives j=0x05, k=0, q=0xAF.
  - CLEAR 0x81 gives j=0, k=0x81, q=0x2E.
- **Stuck bit:** bank model holds bit0 at 0; LOAD 0x01 with MAX_RETRY=2.
  - Required: three DRIVE phases, each with j=0x01, k=0; err pulse in cycle E6→E7; done never asserts; tgt_ready returns to 1.
- **Busy and reset:**
  - Hold tgt_valid=1 with LOAD 0x3C during an active request. Required: accepted at the edge after done; no request is lost or duplicated.
  - Then drop reset_n during DRIVE. Required: j/k=0 immediately; state IDLE after release.
